tester_secuencial: RTL and testbench

TESTER_SECUENCIAL -- requirements
Module: tester_secuencial

---
 rtl/tester_secuencial.sv | 149 ++++++++++++++
 tb/tb_tester_secuencial.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tester_secuencial.sv
// tester_secuencial: stimulus generator producing (A,B) operand vectors in
// directed, exhaustive-sweep or LFSR-random order over a valid/ready handshake.
`default_nettype none

module tester_secuencial #(
  parameter int          K     = 4,
  parameter int          N_VEC = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     modo,
  input  logic           out_ready,
  output logic [K-1:0]   A_valor,
  output logic [K-1:0]   B_valor,
  output logic           out_valid,
  output logic [2*K-1:0] idx,
  output logic           done
);

  localparam int W = 2 * K;

  localparam logic [1:0] C_MODO_DIR   = 2'b00;
  localparam logic [1:0] C_MODO_SWEEP = 2'b01;
  localparam logic [1:0] C_MODO_RAND  = 2'b10;

  localparam logic [K-1:0] C_ONES = '1;
  localparam logic [K-1:0] C_A1   = C_ONES ^ (K'(1) << 1);
  localparam logic [K-1:0] C_B1   = C_ONES ^ (K'(1) << 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     modo_q, modo_d;
  logic [W-1:0]   idx_q, idx_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [K-1:0]   a_q, a_d;
  logic [K-1:0]   b_q, b_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;

  logic [1:0]     modo_norm;
  logic [15:0]    lfsr_next;
  logic [W-1:0]   last_idx;
  logic [W-1:0]   idx_inc;

  // Returns {A,B} for a given mode, index and current LFSR contents.
  function automatic logic [W-1:0] vector_of(input logic [1:0]   m,
                                             input logic [W-1:0] i,
                                             input logic [W-1:0] l);
    logic [W-1:0] v;
    case (m)
      C_MODO_SWEEP: v = i;
      C_MODO_RAND:  v = {l[K-1:0], l[W-1:K]};
      default: begin
        if (i == W'(0))      v = {C_ONES, C_ONES};
        else if (i == W'(1)) v = {C_A1, C_B1};
        else                 v = {{K{1'b0}}, C_B1};
      end
    endcase
    return v;
  endfunction

  always_comb begin
    modo_norm = (modo == 2'b11) ? C_MODO_DIR : modo;
    lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    idx_inc   = idx_q + W'(1);
    case (modo_q)
      C_MODO_SWEEP: last_idx = '1;
      C_MODO_RAND:  last_idx = W'(N_VEC - 1);
      default:      last_idx = W'(2);
    endcase
  end

  always_comb begin
    state_d = state_q;
    modo_d  = modo_q;
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (start) begin
          state_d    = ST_RUN;
          modo_d     = modo_norm;
          idx_d      = '0;
          lfsr_d     = SEED;
          {a_d, b_d} = vector_of(modo_norm, '0, SEED[W-1:0]);
          valid_d    = 1'b1;
          done_d     = 1'b0;
        end
      end
      ST_RUN: begin
        if (valid_q && out_ready) begin
          if (idx_q == last_idx) begin
            // Final transfer: operands and index stay frozen for inspection.
            state_d = ST_FIN;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d      = idx_inc;
            lfsr_d     = lfsr_next;
            {a_d, b_d} = vector_of(modo_q, idx_inc, lfsr_next[W-1:0]);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      modo_q  <= C_MODO_DIR;
      idx_q   <= '0;
      lfsr_q  <= SEED;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      modo_q  <= modo_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign A_valor   = a_q;
  assign B_valor   = b_q;
  assign out_valid = valid_q;
  assign idx       = idx_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_tester_secuencial.sv
// tb_tester_secuencial: directed self-checking bench for tester_secuencial
// with default parameters (K=4, N_VEC=16, SEED=16'hACE1).
`default_nettype none

module tb_tester_secuencial;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] modo;
  logic       out_ready;
  logic [3:0] A_valor;
  logic [3:0] B_valor;
  logic       out_valid;
  logic [7:0] idx;
  logic       done;

  int checks;
  int passed;

  tester_secuencial #(.K(4), .N_VEC(16), .SEED(16'hACE1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .modo      (modo),
    .out_ready (out_ready),
    .A_valor   (A_valor),
    .B_valor   (B_valor),
    .out_valid (out_valid),
    .idx       (idx),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] i);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_A"}, {28'b0, A_valor}, {28'b0, a});
    check({tag, "_B"}, {28'b0, B_valor}, {28'b0, b});
    check({tag, "_idx"}, {24'b0, idx}, {24'b0, i});
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, {31'b0, exp_done});
  endtask

  initial begin
    logic [15:0] m;
    checks    = 0;
    passed    = 0;
    rst_n     = 1'b1;
    start     = 1'b0;
    modo      = 2'b00;
    out_ready = 1'b0;

    // Reset takes effect without any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_A", {28'b0, A_valor}, 32'd0);
    check("rst_B", {28'b0, B_valor}, 32'd0);
    check("rst_idx", {24'b0, idx}, 32'd0);
    check_idle("rst", 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_idle("idle", 1'b0);

    // Directed mode, consumer always ready.
    start = 1'b1; modo = 2'b00; out_ready = 1'b1;
    tick();
    start = 1'b0;
    check_vec("dir_v0", 4'hF, 4'hF, 8'd0);
    tick();
    check_vec("dir_v1", 4'hD, 4'hB, 8'd1);
    tick();
    check_vec("dir_v2", 4'h0, 4'hB, 8'd2);
    tick();
    check_idle("dir_fin", 1'b1);
    check("dir_fin_A", {28'b0, A_valor}, 32'h0);
    check("dir_fin_B", {28'b0, B_valor}, 32'hB);
    check("dir_fin_idx", {24'b0, idx}, 32'd2);
    tick();
    check("dir_sticky", {31'b0, done}, 32'd1);

    // Restart from FIN, then hold backpressure at idx 1.
    start = 1'b1; modo = 2'b00;
    tick();
    start = 1'b0;
    check("rst_fin_done", {31'b0, done}, 32'd0);
    check_vec("bp_v0", 4'hF, 4'hF, 8'd0);
    tick();
    check_vec("bp_v1", 4'hD, 4'hB, 8'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_vec("bp_hold", 4'hD, 4'hB, 8'd1);
    end
    out_ready = 1'b1;
    tick();
    check_vec("bp_v2", 4'h0, 4'hB, 8'd2);
    tick();
    check_idle("bp_fin", 1'b1);

    // modo=11 behaves as directed; start during RUN is ignored.
    start = 1'b1; modo = 2'b11; out_ready = 1'b0;
    tick();
    start = 1'b0;
    check_vec("m3_v0", 4'hF, 4'hF, 8'd0);
    start = 1'b1; modo = 2'b01;
    tick();
    start = 1'b0;
    check_vec("run_start_v0", 4'hF, 4'hF, 8'd0);
    out_ready = 1'b1;
    tick();
    check_vec("run_start_v1", 4'hD, 4'hB, 8'd1);
    tick();
    check_vec("run_start_v2", 4'h0, 4'hB, 8'd2);
    tick();
    check_idle("run_start_fin", 1'b1);

    // Random mode against an independent LFSR model.
    start = 1'b1; modo = 2'b10;
    tick();
    start = 1'b0;
    check_vec("rnd_first", 4'h1, 4'hE, 8'd0);
    m = 16'hACE1;
    for (int i = 0; i < 16; i++) begin
      if (i == 1) check_vec("rnd_second", 4'h3, 4'hC, 8'd1);
      check_vec("rnd", m[3:0], m[7:4], i[7:0]);
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
      tick();
    end
    check_idle("rnd_fin", 1'b1);
    check("rnd_fin_idx", {24'b0, idx}, 32'd15);

    // Exhaustive sweep.
    start = 1'b1; modo = 2'b01;
    tick();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      check_vec("sweep", i[7:4], i[3:0], i[7:0]);
      tick();
    end
    check_idle("sweep_fin", 1'b1);
    check("sweep_fin_idx", {24'b0, idx}, 32'hFF);

    // Asynchronous reset in the middle of a sweep.
    start = 1'b1; modo = 2'b01;
    tick();
    start = 1'b0;
    for (int i = 0; i < 64; i++) tick();
    check_vec("pre_rst", 4'h4, 4'h0, 8'h40);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_A", {28'b0, A_valor}, 32'd0);
    check("mid_rst_B", {28'b0, B_valor}, 32'd0);
    check("mid_rst_idx", {24'b0, idx}, 32'd0);
    check_idle("mid_rst", 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle("post_rst", 1'b0);
      check("post_rst_idx", {24'b0, idx}, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
